// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA timing generator:
//     - vga_state_t : run-control FSM state encoding (IDLE, RUN, DRAIN)
//     - DEF_*       : default 640x480 @ 60 Hz timing (25 MHz pixel rate from
//                     a 100 MHz clk with a divide-by-4 pixel strobe)
//     - cnt_width() : register width needed for a 0..n-1 counter
//   Optional feature macro used by the generator: VGA_TIMING_FRAME_CNT_EN.

package vga_timing_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } vga_state_t;

   // 640x480 horizontal timing, in pixels
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;

   // 640x480 vertical timing, in lines
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   // Both syncs active-low for this mode
   localparam int DEF_SYNC_POL  = 0;
   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_CW        = 11;

   // Width of a counter that runs 0..n-1; never less than one bit so a
   // divide-by-1 still has a legal (constant) register.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_pix_en_div.sv
// vga_pix_en_div
//   Free-running pixel-strobe divider. An internal counter runs
//   0..CLK_DIV-1 and pix_en is high for the single clk in which the counter
//   holds CLK_DIV-1. With CLK_DIV = 1 the strobe is high on every clk after
//   reset.
//
//   Parameters
//     CLK_DIV : clk cycles per pixel (>= 1)
//   Ports
//     clk     in  system clock, rising edge
//     reset   in  synchronous active-high reset (counter 0, pix_en 0)
//     pix_en  out registered one-clk pixel strobe

module vga_pix_en_div
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic reset,
   output logic pix_en
);

   localparam int            DW   = cnt_width(CLK_DIV);
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] cnt_reg;
   logic [DW-1:0] cnt_next;
   logic          pix_en_reg;

   always_comb begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + DW'(1);
   end

   // The strobe is registered from the next count so it lines up with the
   // cycle in which cnt_reg == LAST, yet still reads 0 straight out of reset
   // even when CLK_DIV = 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg    <= '0;
         pix_en_reg <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         pix_en_reg <= (cnt_next == LAST);
      end
   end

   assign pix_en = pix_en_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parameterised VGA raster timing generator. A pixel strobe from
//   vga_pix_en_div paces an x/y raster counter wrapped in a three-state
//   run-control FSM:
//     IDLE  : counters parked at (0,0), syncs inactive, video_on low
//     RUN   : raster counts while enable is high
//     DRAIN : enable dropped; the current frame is finished before IDLE,
//             and raising enable again resumes RUN without disturbing x/y
//   Every output (syncs, video_on, line/frame pulses) is registered from the
//   next-counter values, so it is cycle-aligned with x/y.
//
//   Optional feature (macro VGA_TIMING_FRAME_CNT_EN):
//     defined   -> frame_cnt counts completed frames, wrapping 255 -> 0
//     undefined -> frame_cnt is tied to 0 and no counter is built
//
//   Parameters
//     H_DISPLAY/H_FRONT/H_SYNC/H_BACK : line layout in pixels
//     V_DISPLAY/V_FRONT/V_SYNC/V_BACK : frame layout in lines
//     SYNC_POL : active sync level (0 = active-low)
//     CLK_DIV  : clk cycles per pixel (>= 1)
//     CW       : x/y counter width
//   Ports
//     clk         in  system clock, rising edge
//     reset       in  synchronous active-high reset
//     enable      in  level-sensitive run request
//     pix_en      out one-clk pixel strobe every CLK_DIV clks
//     hsync       out horizontal sync
//     vsync       out vertical sync
//     video_on    out visible-area flag
//     x, y        out raster position
//     line_start  out one-clk pulse when x becomes 0 on a running line
//     frame_start out one-clk pulse when (x,y) becomes (0,0) on a new frame
//     frame_cnt   out completed-frame counter

module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter int SYNC_POL  = DEF_SYNC_POL,
   parameter int CLK_DIV   = DEF_CLK_DIV,
   parameter int CW        = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          enable,
   output logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          video_on,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
);

   localparam int            HMAX     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
   localparam int            VMAX     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;
   localparam logic [CW-1:0] HMAX_C   = CW'(HMAX);
   localparam logic [CW-1:0] VMAX_C   = CW'(VMAX);
   localparam logic          SYNC_ACT = (SYNC_POL != 0);

   // ------------------------------------------------------------------
   // Pixel strobe
   // ------------------------------------------------------------------
   vga_pix_en_div #(
      .CLK_DIV (CLK_DIV)
   ) u_div (
      .clk    (clk),
      .reset  (reset),
      .pix_en (pix_en)
   );

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   vga_state_t    state_reg;
   vga_state_t    state_next;
   logic [CW-1:0] x_reg;
   logic [CW-1:0] x_next;
   logic [CW-1:0] y_reg;
   logic [CW-1:0] y_next;
   logic          hsync_reg;
   logic          vsync_reg;
   logic          video_on_reg;
   logic          line_start_reg;
   logic          line_start_next;
   logic          frame_start_reg;
   logic          frame_start_next;

   logic          end_of_line;
   logic          end_of_frame;
   logic          running_next;

   assign end_of_line  = (x_reg == HMAX_C);
   assign end_of_frame = end_of_line && (y_reg == VMAX_C);

   // ------------------------------------------------------------------
   // Next-state / next-counter logic. Nothing moves except on a strobe
   // clk; on the other clks the pulses fall back to 0 and levels hold.
   // ------------------------------------------------------------------
   always_comb begin
      state_next       = state_reg;
      x_next           = x_reg;
      y_next           = y_reg;
      line_start_next  = 1'b0;
      frame_start_next = 1'b0;

      if (pix_en) begin
         case (state_reg)
            IDLE: begin
               // Counters already sit at (0,0): starting simply presents
               // that position as the first pixel of a new frame.
               if (enable) begin
                  state_next       = RUN;
                  line_start_next  = 1'b1;
                  frame_start_next = 1'b1;
               end
            end

            RUN, DRAIN: begin
               if (end_of_line) begin
                  x_next = '0;
                  y_next = end_of_frame ? '0 : y_reg + CW'(1);
               end else begin
                  x_next = x_reg + CW'(1);
               end

               if (enable) begin
                  state_next = RUN;
               end else if (state_reg == RUN) begin
                  state_next = DRAIN;
               end else if (end_of_frame) begin
                  state_next = IDLE;
               end else begin
                  state_next = DRAIN;
               end

               // Returning to IDLE parks at (0,0) but begins no new line
               // or frame, so neither pulse fires on that edge.
               line_start_next  = end_of_line  && (state_next != IDLE);
               frame_start_next = end_of_frame && (state_next != IDLE);
            end

            default: begin
               state_next = IDLE;
               x_next     = '0;
               y_next     = '0;
            end
         endcase
      end
   end

   assign running_next = (state_next != IDLE);

   // ------------------------------------------------------------------
   // Per-axis decode of the next position: index 0 is horizontal (x),
   // index 1 is vertical (y). Both axes share the same layout order:
   // display, front porch, sync, back porch.
   // ------------------------------------------------------------------
   logic [CW-1:0] pos_next [2];
   logic [1:0]    in_disp_next;
   logic [1:0]    in_sync_next;

   assign pos_next[0] = x_next;
   assign pos_next[1] = y_next;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         localparam int DISP_LEN   = (gi == 0) ? H_DISPLAY : V_DISPLAY;
         localparam int SYNC_FIRST = (gi == 0) ? (H_DISPLAY + H_FRONT) : (V_DISPLAY + V_FRONT);
         localparam int SYNC_LAST  = SYNC_FIRST + ((gi == 0) ? H_SYNC : V_SYNC) - 1;

         assign in_disp_next[gi] = (pos_next[gi] < CW'(DISP_LEN));
         assign in_sync_next[gi] = (pos_next[gi] >= CW'(SYNC_FIRST)) &&
                                   (pos_next[gi] <= CW'(SYNC_LAST));
      end
   endgenerate

   // ------------------------------------------------------------------
   // FSM state, counters and outputs share one register stage so that
   // every output is aligned with the x/y it describes.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         x_reg           <= '0;
         y_reg           <= '0;
         hsync_reg       <= ~SYNC_ACT;
         vsync_reg       <= ~SYNC_ACT;
         video_on_reg    <= 1'b0;
         line_start_reg  <= 1'b0;
         frame_start_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         x_reg           <= x_next;
         y_reg           <= y_next;
         hsync_reg       <= (running_next && in_sync_next[0]) ? SYNC_ACT : ~SYNC_ACT;
         vsync_reg       <= (running_next && in_sync_next[1]) ? SYNC_ACT : ~SYNC_ACT;
         video_on_reg    <= running_next && in_disp_next[0] && in_disp_next[1];
         line_start_reg  <= line_start_next;
         frame_start_reg <= frame_start_next;
      end
   end

   assign x           = x_reg;
   assign y           = y_reg;
   assign hsync       = hsync_reg;
   assign vsync       = vsync_reg;
   assign video_on    = video_on_reg;
   assign line_start  = line_start_reg;
   assign frame_start = frame_start_reg;

   // ------------------------------------------------------------------
   // Completed-frame counter. A frame completes on every (HMAX,VMAX)
   // wrap, including the final one that drops a draining raster to IDLE.
   // ------------------------------------------------------------------
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] frame_cnt_reg;
   logic       frame_wrap;

   assign frame_wrap = pix_en && (state_reg != IDLE) && end_of_frame;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt_reg <= 8'd0;
      end else if (frame_wrap) begin
         frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_reg;
`else
   assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. Two instances share one clock:
//     dut_a : default 640x480 timing, CLK_DIV=4, active-low syncs
//     dut_b : tiny raster H=8/2/2/2, V=4/1/1/1, CLK_DIV=1, active-high syncs
//             (14 px/line, 7 lines/frame, 98 clks/frame)
//   Expected frame_cnt values follow VGA_TIMING_FRAME_CNT_EN.

module tb_vga_timing_gen;

`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam int FC_ON = 1;
`else
   localparam int FC_ON = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_reset, a_enable, a_pix_en, a_hsync, a_vsync, a_video_on;
   logic        a_line_start, a_frame_start;
   logic [10:0] a_x, a_y;
   logic [7:0]  a_frame_cnt;

   logic        b_reset, b_enable, b_pix_en, b_hsync, b_vsync, b_video_on;
   logic        b_line_start, b_frame_start;
   logic [10:0] b_x, b_y;
   logic [7:0]  b_frame_cnt;

   vga_timing_gen dut_a (
      .clk         (clk),
      .reset       (a_reset),
      .enable      (a_enable),
      .pix_en      (a_pix_en),
      .hsync       (a_hsync),
      .vsync       (a_vsync),
      .video_on    (a_video_on),
      .x           (a_x),
      .y           (a_y),
      .line_start  (a_line_start),
      .frame_start (a_frame_start),
      .frame_cnt   (a_frame_cnt)
   );

   vga_timing_gen #(
      .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
      .V_DISPLAY (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
      .SYNC_POL  (1), .CLK_DIV (1), .CW (11)
   ) dut_b (
      .clk         (clk),
      .reset       (b_reset),
      .enable      (b_enable),
      .pix_en      (b_pix_en),
      .hsync       (b_hsync),
      .vsync       (b_vsync),
      .video_on    (b_video_on),
      .x           (b_x),
      .y           (b_y),
      .line_start  (b_line_start),
      .frame_start (b_frame_start),
      .frame_cnt   (b_frame_cnt)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   int cont_bad     = 0;
   int fs_seen      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = %0d", tag, got);
      end
   endtask

   // Step dut_b n clks, counting raster-sequence breaks and frame_start pulses.
   task automatic advance_b(input int n);
      logic [10:0] px, py, ex, ey;
      for (int i = 0; i < n; i++) begin
         px = b_x;
         py = b_y;
         @(negedge clk);
         if (px == 11'd13) begin
            ex = 11'd0;
            ey = (py == 11'd6) ? 11'd0 : py + 11'd1;
         end else begin
            ex = px + 11'd1;
            ey = py;
         end
         if (b_x !== ex || b_y !== ey) cont_bad++;
         if (b_frame_start) fs_seen++;
      end
   endtask

   initial begin
      int  k, pe_cnt, fs_k, first_lo, last_lo, max_x, hs_lo, vs_lo, vid_bad;
      int  ls_cnt, ls_last, ls_period, fs_cnt;
      int  mx, my, hs_bad, hs_hi, vs_bad, vs_hi, vid_hi, ls_n, fs_n, pe_lo, nz;
      logic ls4, vid4;

      a_reset = 1'b1; a_enable = 1'b0;
      b_reset = 1'b1; b_enable = 1'b0;
      ls4 = 1'b0; vid4 = 1'b0;
      repeat (3) @(negedge clk);

      // ---------------- reset state ----------------
      check("a_rst_x", a_x, 0);
      check("a_rst_y", a_y, 0);
      check("a_rst_pix_en", a_pix_en, 0);
      check("a_rst_hsync", a_hsync, 1);
      check("a_rst_vsync", a_vsync, 1);
      check("a_rst_video_on", a_video_on, 0);
      check("a_rst_pulses", {a_line_start, a_frame_start}, 0);
      check("a_rst_frame_cnt", a_frame_cnt, 0);
      check("b_rst_syncs", {b_hsync, b_vsync}, 0);

      // ---------------- default timing: strobe and start ----------------
      a_reset = 1'b0; a_enable = 1'b1;
      pe_cnt = 0; fs_k = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (a_pix_en) pe_cnt++;
         if (i == 4) begin ls4 = a_line_start; vid4 = a_video_on; end
         if (a_frame_start && fs_k < 0) fs_k = i;
      end
      check("a_pix_en_in_40clk", pe_cnt, 10);
      check("a_first_frame_start_clk", fs_k, 4);
      check("a_first_line_start", ls4, 1);
      check("a_first_video_on", vid4, 1);
      check("a_x_at_clk40", a_x, 9);

      // ---------------- default timing: two full lines ----------------
      first_lo = -1; last_lo = -1; max_x = 0; hs_lo = 0; vs_lo = 0; vid_bad = 0;
      ls_cnt = 0; ls_last = -1; ls_period = 0; fs_cnt = 0;
      for (int kk = 41; kk <= 6409; kk++) begin
         @(negedge clk);
         if (a_hsync == 1'b0) begin
            if (first_lo < 0) first_lo = int'(a_x);
            last_lo = int'(a_x);
            hs_lo++;
         end
         if (int'(a_x) > max_x) max_x = int'(a_x);
         if (a_vsync == 1'b0) vs_lo++;
         if (a_video_on != (a_x < 11'd640)) vid_bad++;
         if (a_frame_start) fs_cnt++;
         if (a_line_start) begin
            ls_cnt++;
            if (ls_last >= 0) ls_period = kk - ls_last;
            ls_last = kk;
         end
      end
      check("a_hsync_first_x", first_lo, 656);
      check("a_hsync_last_x", last_lo, 751);
      check("a_hsync_low_clks", hs_lo, 768);
      check("a_max_x", max_x, 799);
      check("a_line_start_count", ls_cnt, 2);
      check("a_line_period_clk", ls_period, 3200);
      check("a_vsync_low_clks", vs_lo, 0);
      check("a_video_on_bad", vid_bad, 0);
      check("a_frame_start_midframe", fs_cnt, 0);
      check("a_y_after_2_lines", a_y, 2);
      check("a_x_after_2_lines", a_x, 1);

      // ---------------- default timing: reset mid-frame ----------------
      repeat (1195) @(negedge clk);
      check("a_x_before_reset", a_x, 300);
      a_reset = 1'b1;
      @(negedge clk);
      check("a_mid_rst_xy", {a_x, a_y}, 0);
      check("a_mid_rst_pix_en", a_pix_en, 0);
      check("a_mid_rst_syncs", {a_hsync, a_vsync}, 3);
      check("a_mid_rst_video_pulses", {a_video_on, a_line_start, a_frame_start}, 0);
      check("a_mid_rst_frame_cnt", a_frame_cnt, 0);
      a_reset = 1'b0;
      k = 0;
      while (k < 20 && !a_frame_start) begin @(negedge clk); k++; end
      check("a_restart_frame_start_clk", k, 4);

      // ---------------- small raster: first frame ----------------
      b_reset = 1'b0; b_enable = 1'b1;
      k = 0;
      while (k < 10 && !b_frame_start) begin @(negedge clk); k++; end
      check("b_first_frame_start_clk", k, 2);
      mx = 0; my = 0; hs_bad = 0; hs_hi = 0; vs_bad = 0; vs_hi = 0;
      vid_bad = 0; vid_hi = 0; ls_n = 0; fs_n = 0; pe_lo = 0;
      for (int j = 0; j < 98; j++) begin
         if (int'(b_x) > mx) mx = int'(b_x);
         if (int'(b_y) > my) my = int'(b_y);
         if (b_hsync != (b_x == 11'd10 || b_x == 11'd11)) hs_bad++;
         if (b_hsync) hs_hi++;
         if (b_vsync != (b_y == 11'd5)) vs_bad++;
         if (b_vsync) vs_hi++;
         if (b_video_on != (b_x < 11'd8 && b_y < 11'd4)) vid_bad++;
         if (b_video_on) vid_hi++;
         if (b_line_start) ls_n++;
         if (b_frame_start) fs_n++;
         if (!b_pix_en) pe_lo++;
         @(negedge clk);
      end
      check("b_max_x", mx, 13);
      check("b_max_y", my, 6);
      check("b_hsync_bad", hs_bad, 0);
      check("b_hsync_high_clks", hs_hi, 14);
      check("b_vsync_bad", vs_bad, 0);
      check("b_vsync_high_clks", vs_hi, 14);
      check("b_video_on_bad", vid_bad, 0);
      check("b_video_on_clks", vid_hi, 32);
      check("b_line_starts", ls_n, 7);
      check("b_frame_starts", fs_n, 1);
      check("b_pix_en_low_clks", pe_lo, 0);
      check("b_wrap_frame_start", b_frame_start, 1);
      check("b_wrap_xy", {b_x, b_y}, 0);
      check("b_frame_cnt_1", b_frame_cnt, FC_ON ? 1 : 0);

      // ---------------- enable dropped at y=2: drain to IDLE ----------------
      cont_bad = 0; fs_seen = 0;
      advance_b(28);
      check("b_drop_at_y", b_y, 2);
      b_enable = 1'b0;
      advance_b(69);
      check("b_drain_last_xy", {b_x, b_y}, {11'd13, 11'd6});
      advance_b(1);
      check("b_drain_continuity", cont_bad, 0);
      check("b_drain_no_frame_start", fs_seen, 0);
      check("b_idle_syncs", {b_hsync, b_vsync}, 0);
      check("b_idle_video_on", b_video_on, 0);
      check("b_frame_cnt_2", b_frame_cnt, FC_ON ? 2 : 0);
      nz = 0;
      repeat (5) begin
         @(negedge clk);
         if (b_x != 11'd0 || b_y != 11'd0 || b_video_on || b_frame_start) nz++;
      end
      check("b_idle_hold", nz, 0);

      // ---------------- restart, drop, re-raise in DRAIN ----------------
      b_enable = 1'b1;
      @(negedge clk);
      check("b_restart_frame_start", b_frame_start, 1);
      cont_bad = 0; fs_seen = 0;
      advance_b(14);
      check("b_drop2_at_y", b_y, 1);
      b_enable = 1'b0;
      advance_b(28);
      check("b_raise_at_y", b_y, 3);
      b_enable = 1'b1;
      advance_b(55);
      check("b_resume_no_early_fs", fs_seen, 0);
      advance_b(1);
      check("b_resume_frame_start", b_frame_start, 1);
      check("b_resume_continuity", cont_bad, 0);
      check("b_frame_cnt_3", b_frame_cnt, FC_ON ? 3 : 0);

      // ---------------- 256 frames: counter wrap ----------------
      repeat (252 * 98) @(negedge clk);
      check("b_frame_cnt_255", b_frame_cnt, FC_ON ? 255 : 0);
      repeat (98) @(negedge clk);
      check("b_frame256_start", b_frame_start, 1);
      check("b_frame_cnt_wrap", b_frame_cnt, 0);

      // ---------------- small raster: reset mid-frame ----------------
      advance_b(33);
      check("b_before_reset_xy", {b_x, b_y}, {11'd5, 11'd2});
      b_reset = 1'b1;
      @(negedge clk);
      check("b_mid_rst_xy", {b_x, b_y}, 0);
      check("b_mid_rst_pix_en", b_pix_en, 0);
      check("b_mid_rst_syncs", {b_hsync, b_vsync}, 0);
      check("b_mid_rst_video_pulses", {b_video_on, b_line_start, b_frame_start}, 0);
      check("b_mid_rst_frame_cnt", b_frame_cnt, 0);
      b_reset = 1'b0;
      k = 0;
      while (k < 10 && !b_frame_start) begin @(negedge clk); k++; end
      check("b_restart_frame_start_clk", k, 2);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, 0, active sync level for both syncs (0 = active-low).
REQ-010 Parameter CLK_DIV, 4, clk cycles per pixel (>= 1).
REQ-011 Parameter CW, 11, width of x/y counters.
REQ-012 clk  in  1  single system clock; all logic on its rising edge.
REQ-013 reset  in  1  synchronous, active-high reset.
REQ-014 enable  in  1  run request; level-sensitive.
REQ-015 pix_en  out  1  one-clk pixel strobe every CLK_DIV clks.
REQ-016 hsync  out  1  horizontal sync, level per SYNC_POL.
REQ-017 vsync  out  1  vertical sync, level per SYNC_POL.
REQ-018 video_on  out  1  high when x < H_DISPLAY and y < V_DISPLAY while running.
REQ-019 x  out  CW  pixel column, 0..HMAX (HMAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1).
REQ-020 y  out  CW  line, 0..VMAX (VMAX = V_DISPLAY+V_FRONT+V_SYNC+V_BACK-1).
REQ-021 line_start  out  1  one-clk pulse on the edge x becomes 0.
REQ-022 frame_start  out  1  one-clk pulse on the edge (x,y) becomes (0,0).
REQ-023 frame_cnt  out  8  completed-frame counter.

Function
REQ-024 pix_en: free-running divider, counts 0..CLK_DIV-1, pix_en high in the cycle it equals CLK_DIV-1; CLK_DIV=1 gives pix_en constantly high.
REQ-025 FSM states IDLE, RUN, DRAIN; transitions evaluated only on clks with pix_en=1.
REQ-026 IDLE: x=y=0, syncs inactive, video_on=0; enable=1 -> RUN, same edge presents (0,0) with frame_start=1, line_start=1.
REQ-027 RUN: x increments per pix_en; at HMAX x wraps to 0 and y increments; at (HMAX,VMAX) both wrap to 0; enable=0 -> DRAIN.
REQ-028 DRAIN: counting continues as RUN; enable=1 -> RUN with no counter disturbance; wrap at (HMAX,VMAX) with enable=0 -> IDLE, no frame_start.
REQ-029 Line order: display, front porch, sync, back porch; hsync active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; vsync likewise on y.
REQ-030 hsync, vsync, video_on, line_start, frame_start are registered from next-counter values, aligned with x/y in the same cycle (zero skew, one-clk pipeline).
REQ-031 frame_cnt increments on each RUN/DRAIN wrap (HMAX,VMAX)->(0,0), wraps 255->0, holds in IDLE.

Reset
REQ-032 reset=1 at any clk, including mid-frame, forces next cycle: IDLE, divider 0, x=y=0, pix_en=0, syncs inactive (=~SYNC_POL), video_on=0, pulses 0, frame_cnt=0.

Configuration
REQ-033 Macro VGA_TIMING_FRAME_CNT_EN defined: frame_cnt per REQ-031; undefined: frame_cnt tied to 0, no counter register built.

Structure
REQ-034 Package vga_timing_pkg holds FSM state typedef and 640x480 default timing constants.
REQ-035 Divider is sub-module vga_pix_en_div (params CLK_DIV; ports clk, reset, pix_en).

Verification
REQ-036 Defaults, enable=1: pix_en every 4 clk; hsync low for x 656..751; 800 px/line; vsync low for y 490..491; frame_start period 1,680,000 clk.
REQ-037 H=8/2/2/2, V=4/1/1/1, CLK_DIV=1: x cycles 0..13, hsync active x=10..11, VMAX=6, vsync active y=5, video_on for x<8,y<4.
REQ-038 enable dropped at y=100 -> counting to (HMAX,VMAX) then IDLE, (0,0); re-raise in DRAIN at y=200 -> no glitch, frame_start at next wrap.
REQ-039 reset at x=300,y=200 -> next clk all outputs at REQ-032 values; enable held -> restart with frame_start.
REQ-040 SYNC_POL=1 -> syncs active-high; 256 small-param frames -> frame_cnt 255->0 with macro, constant 0 without.
